// File: rtl/shift_tx_sequencer.sv
// Parallel-to-serial transmit sequencer: takes a word over valid/ready and sends it MSB first,
// one bit per DIV clocks. Defining PARITY_EN appends an even-parity bit to each frame.
module shift_tx_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers on a posedge where in_valid and in_ready are both high;
    // in_ready is high only in IDLE, so in_data is only looked at on that edge.

    localparam int BW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
`ifdef PARITY_EN
        ,
        S_PAR   = 2'd3
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [PW-1:0]    pre_cnt;
    logic             ser_out_q;
    logic             bit_end;
    logic             last_bit;
`ifdef PARITY_EN
    logic             parity_q;
`endif

    assign bit_end   = (pre_cnt == PRE_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort takes priority over the end-of-frame transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_end && last_bit) begin
`ifdef PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ser_out_q is loaded one edge ahead with the bit the next state will present
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            ser_out_q <= 1'b0;
`ifdef PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        bit_cnt   <= '0;
                        pre_cnt   <= '0;
                        ser_out_q <= in_data[WIDTH-1];
`ifdef PARITY_EN
                        parity_q  <= ^in_data;
`endif
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        ser_out_q <= 1'b0;
                        bit_cnt   <= '0;
                        pre_cnt   <= '0;
                    end else if (bit_end) begin
                        pre_cnt <= '0;
                        bit_cnt <= bit_cnt + BW'(1);
                        shreg   <= shreg << 1;
                        if (last_bit) begin
`ifdef PARITY_EN
                            ser_out_q <= parity_q;
`else
                            ser_out_q <= 1'b0;
`endif
                        end else begin
                            ser_out_q <= shreg[WIDTH-2];
                        end
                    end else begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end
`ifdef PARITY_EN
                S_PAR: begin
                    if (abort || bit_end) begin
                        ser_out_q <= 1'b0;
                        pre_cnt   <= '0;
                    end else begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end
`endif
                default: begin
                    ser_out_q <= 1'b0;
                    pre_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        ser_en   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        ser_out  = ser_out_q;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_SHIFT: ser_en = 1'b1;
`ifdef PARITY_EN
            S_PAR:   ser_en = 1'b1;
`endif
            S_DONE:  done   = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

endmodule
